// File: rtl/branch_pkg.sv
// Shared op encodings, condition codes and the registered result record for branch resolution.
package branch_pkg;

   localparam int BR_XMAX = 64;

   typedef enum logic [1:0] {
      BR_COND = 2'd0,
      BR_JAL  = 2'd1,
      BR_JALR = 2'd2,
      BR_RSV  = 2'd3
   } br_op_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Address fields are sized for the widest core; narrower builds use the low XLEN bits.
   typedef struct packed {
      logic               taken;
      logic [BR_XMAX-1:0] target;
      logic [BR_XMAX-1:0] link;
      logic               mispredict;
      logic               misaligned;
      logic               illegal;
   } br_res_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of the six conditional-branch compares; flags the two unused funct3 codes.
module branch_cond_eval
   import branch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   input  logic [2:0]      i_funct3,
   output logic            o_cond_true,
   output logic            o_illegal_f3
);

   logic w_eq;
   logic w_lt;
   logic w_ltu;

   assign w_eq  = (i_rs1 == i_rs2);
   assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
   assign w_ltu = (i_rs1 < i_rs2);

   always_comb begin
      o_cond_true  = 1'b0;
      o_illegal_f3 = 1'b0;
      case (i_funct3)
         F3_BEQ:  o_cond_true = w_eq;
         F3_BNE:  o_cond_true = !w_eq;
         F3_BLT:  o_cond_true = w_lt;
         F3_BGE:  o_cond_true = !w_lt;
         F3_BLTU: o_cond_true = w_ltu;
         F3_BGEU: o_cond_true = !w_ltu;
         default: o_illegal_f3 = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution with a single registered result slot: 1-cycle latency, full throughput.
// Backpressure: in_ready = !out_valid || out_ready; result held while stalled. Optional BRU_PERF_COUNTERS_EN.
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int IALIGN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_op,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic            in_pred_taken,
   input  logic [XLEN-1:0] in_pred_target,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_taken,
   output logic [XLEN-1:0] out_target,
   output logic [XLEN-1:0] out_link,
   output logic            out_mispredict,
   output logic            out_misaligned,
   output logic            out_illegal
`ifdef BRU_PERF_COUNTERS_EN
   ,
   output logic [31:0]     perf_branches,
   output logic [31:0]     perf_mispredicts
`endif
);

   br_op_e          w_op;
   logic            w_cond_true;
   logic            w_illegal_f3;
   logic [XLEN-1:0] w_link;
   logic [XLEN-1:0] w_pc_tgt;
   logic [XLEN-1:0] w_jalr_sum;
   logic [XLEN-1:0] w_tgt;
   logic [XLEN-1:0] w_next;
   logic            w_taken;
   logic            w_illegal;
   logic            w_mispredict;
   logic            w_misaligned;
   logic            w_accept;
   br_res_t         w_res;

   logic            r_vld;
   br_res_t         r_res;

   assign w_op = br_op_e'(in_op);

   branch_cond_eval #(.XLEN(XLEN)) u_cond (
      .i_rs1        (in_rs1),
      .i_rs2        (in_rs2),
      .i_funct3     (in_funct3),
      .o_cond_true  (w_cond_true),
      .o_illegal_f3 (w_illegal_f3)
   );

   assign w_link     = in_pc + XLEN'(4);
   assign w_pc_tgt   = in_pc + in_imm;
   assign w_jalr_sum = in_rs1 + in_imm;

   always_comb begin
      w_illegal = 1'b0;
      w_taken   = 1'b0;
      w_tgt     = w_pc_tgt;
      case (w_op)
         BR_COND: begin
            w_illegal = w_illegal_f3;
            w_taken   = w_cond_true && !w_illegal_f3;
         end
         BR_JAL:  w_taken = 1'b1;
         BR_JALR: begin
            w_taken = 1'b1;
            w_tgt   = {w_jalr_sum[XLEN-1:1], 1'b0};
         end
         default: w_illegal = 1'b1;
      endcase
   end

   assign w_next = w_taken ? w_tgt : w_link;

   // Predicted target only matters when both sides agree the op is taken.
   assign w_mispredict = !w_illegal &&
                         ((in_pred_taken != w_taken) || (w_taken && (in_pred_target != w_tgt)));
   assign w_misaligned = (IALIGN == 32) && w_taken && w_tgt[1];

   always_comb begin
      w_res            = '0;
      w_res.taken      = w_taken;
      w_res.target     = BR_XMAX'(w_next);
      w_res.link       = BR_XMAX'(w_link);
      w_res.mispredict = w_mispredict;
      w_res.misaligned = w_misaligned;
      w_res.illegal    = w_illegal;
   end

   // in_ready reflects the pre-flush state; flush only suppresses the load itself.
   assign in_ready = !r_vld || out_ready;
   assign w_accept = in_valid && in_ready && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= 1'b0;
         r_res <= '0;
      end else if (flush) begin
         r_vld <= 1'b0;
      end else if (w_accept) begin
         r_vld <= 1'b1;
         r_res <= w_res;
      end else if (out_ready) begin
         r_vld <= 1'b0;
      end
   end

   assign out_valid      = r_vld;
   assign out_taken      = r_res.taken;
   assign out_target     = r_res.target[XLEN-1:0];
   assign out_link       = r_res.link[XLEN-1:0];
   assign out_mispredict = r_res.mispredict;
   assign out_misaligned = r_res.misaligned;
   assign out_illegal    = r_res.illegal;

   generate
      if (XLEN < BR_XMAX) begin : g_hi
         logic w_unused_hi;
         assign w_unused_hi = ^{r_res.target[BR_XMAX-1:XLEN], r_res.link[BR_XMAX-1:XLEN]};
      end
   endgenerate

`ifdef BRU_PERF_COUNTERS_EN
   logic [31:0] r_perf_br;
   logic [31:0] r_perf_mp;
   logic        w_handoff;

   // Counted at handoff so a flushed, never-consumed result is not counted.
   assign w_handoff = r_vld && out_ready && !r_res.illegal;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_br <= '0;
         r_perf_mp <= '0;
      end else if (w_handoff) begin
         if (r_perf_br != '1) r_perf_br <= r_perf_br + 32'd1;
         if (r_res.mispredict && (r_perf_mp != '1)) r_perf_mp <= r_perf_mp + 32'd1;
      end
   end

   assign perf_branches    = r_perf_br;
   assign perf_mispredicts = r_perf_mp;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: directed plan items, then randomized traffic against a queue-based reference model.
module tb_branch_resolve_unit;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
      logic [31:0] link;
      logic        mispredict;
      logic        misaligned;
      logic        illegal;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [1:0]  in_op;
   logic [2:0]  in_funct3;
   logic [31:0] in_pc, in_imm, in_rs1, in_rs2, in_pred_target, out_target, out_link;
   logic        in_pred_taken, out_taken, out_mispredict, out_misaligned, out_illegal;

   logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
   logic [1:0]  d_in_op;
   logic [2:0]  d_in_funct3;
   logic [63:0] d_in_pc, d_in_imm, d_in_rs1, d_in_rs2, d_in_pred_target, d_out_target, d_out_link;
   logic        d_in_pred_taken, d_out_taken, d_out_mispredict, d_out_misaligned, d_out_illegal;

   int          total = 0;
   int          bad = 0;
   exp_t        q[$];

   logic [1:0]  s_op;
   logic [2:0]  s_f3;
   logic [31:0] s_pc, s_imm, s_rs1, s_rs2, s_ptg;
   logic        s_pt;

   always #5 clk = ~clk;

   branch_resolve_unit #(.XLEN(32), .IALIGN(32)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pred_taken(in_pred_taken),
      .in_pred_target(in_pred_target), .out_valid(out_valid), .out_ready(out_ready),
      .out_taken(out_taken), .out_target(out_target), .out_link(out_link),
      .out_mispredict(out_mispredict), .out_misaligned(out_misaligned), .out_illegal(out_illegal)
   );

   branch_resolve_unit #(.XLEN(64), .IALIGN(32)) u_dut64 (
      .clk(clk), .rst(rst), .flush(1'b0), .in_valid(d_in_valid), .in_ready(d_in_ready),
      .in_op(d_in_op), .in_funct3(d_in_funct3), .in_pc(d_in_pc), .in_imm(d_in_imm),
      .in_rs1(d_in_rs1), .in_rs2(d_in_rs2), .in_pred_taken(d_in_pred_taken),
      .in_pred_target(d_in_pred_target), .out_valid(d_out_valid), .out_ready(d_out_ready),
      .out_taken(d_out_taken), .out_target(d_out_target), .out_link(d_out_link),
      .out_mispredict(d_out_mispredict), .out_misaligned(d_out_misaligned), .out_illegal(d_out_illegal)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t ref_model(input logic [1:0] op, input logic [2:0] f3,
                                      input logic [31:0] pc, input logic [31:0] imm,
                                      input logic [31:0] rs1, input logic [31:0] rs2,
                                      input logic pt, input logic [31:0] ptg);
      exp_t        r;
      logic [31:0] t;
      logic        tk, ill;
      tk = 1'b0;
      ill = 1'b0;
      t = pc + imm;
      if (op == 2'd0) begin
         case (f3)
            3'b000:  tk = (rs1 == rs2);
            3'b001:  tk = (rs1 != rs2);
            3'b100:  tk = ($signed(rs1) < $signed(rs2));
            3'b101:  tk = ($signed(rs1) >= $signed(rs2));
            3'b110:  tk = (rs1 < rs2);
            3'b111:  tk = (rs1 >= rs2);
            default: ill = 1'b1;
         endcase
      end else if (op == 2'd1) begin
         tk = 1'b1;
      end else if (op == 2'd2) begin
         tk = 1'b1;
         t = (rs1 + imm) & 32'hFFFF_FFFE;
      end else begin
         ill = 1'b1;
      end
      r.taken      = tk;
      r.link       = pc + 32'd4;
      r.target     = tk ? t : pc + 32'd4;
      r.illegal    = ill;
      r.mispredict = !ill && ((pt != tk) || (tk && ptg != t));
      r.misaligned = tk && t[1];
      return r;
   endfunction

   task automatic chk_out();
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         chk("out_taken", 64'(out_taken), 64'(q[0].taken));
         chk("out_target", 64'(out_target), 64'(q[0].target));
         chk("out_link", 64'(out_link), 64'(q[0].link));
         chk("out_mispredict", 64'(out_mispredict), 64'(q[0].mispredict));
         chk("out_misaligned", 64'(out_misaligned), 64'(q[0].misaligned));
         chk("out_illegal", 64'(out_illegal), 64'(q[0].illegal));
      end
   endtask

   // One clock: drive s_* plus handshake controls, check in_ready, advance model, check outputs.
   task automatic cyc(input logic v, input logic ordy, input logic fl, output logic acc);
      logic m_rdy;
      exp_t e;
      in_valid = v; in_op = s_op; in_funct3 = s_f3; in_pc = s_pc; in_imm = s_imm;
      in_rs1 = s_rs1; in_rs2 = s_rs2; in_pred_taken = s_pt; in_pred_target = s_ptg;
      out_ready = ordy; flush = fl;
      #1;
      m_rdy = (q.size() == 0) || ordy;
      chk("in_ready", 64'(in_ready), 64'(m_rdy));
      acc = v && m_rdy && !fl;
      e = ref_model(s_op, s_f3, s_pc, s_imm, s_rs1, s_rs2, s_pt, s_ptg);
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else begin
         if (q.size() != 0 && ordy) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
      #1;
      chk_out();
   endtask

   initial begin
      logic        acc;
      logic [11:0] r12;
      int          idx;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_op = '0; in_funct3 = '0; in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0;
      in_pred_taken = 1'b0; in_pred_target = '0;
      s_op = '0; s_f3 = '0; s_pc = '0; s_imm = '0; s_rs1 = '0; s_rs2 = '0; s_pt = 1'b0; s_ptg = '0;
      d_in_valid = 1'b0; d_out_ready = 1'b1; d_in_op = '0; d_in_funct3 = '0; d_in_pc = '0;
      d_in_imm = '0; d_in_rs1 = '0; d_in_rs2 = '0; d_in_pred_taken = 1'b0; d_in_pred_target = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_taken", 64'(out_taken), 64'd0);
      chk("rst_out_target", 64'(out_target), 64'd0);
      chk("rst_out_link", 64'(out_link), 64'd0);
      chk("rst_out_flags", 64'({out_mispredict, out_misaligned, out_illegal}), 64'd0);
      chk("rst_d64_valid", 64'(d_out_valid), 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // 64-bit instance: signed BGE at the sign boundary and a wrapping BEQ target.
      d_in_valid = 1'b1; d_in_op = 2'd0; d_in_funct3 = 3'b101;
      d_in_rs1 = 64'h8000_0000_0000_0000; d_in_rs2 = 64'd0; d_in_pc = 64'h100; d_in_imm = 64'h10;
      @(posedge clk); #1;
      chk("x64_bge_valid", 64'(d_out_valid), 64'd1);
      chk("x64_bge_taken", 64'(d_out_taken), 64'd0);
      chk("x64_bge_target", d_out_target, 64'h104);
      d_in_funct3 = 3'b000; d_in_rs1 = 64'd5; d_in_rs2 = 64'd5;
      d_in_pc = 64'hFFFF_FFFF_FFFF_FFFC; d_in_imm = 64'd8; d_in_pred_taken = 1'b1; d_in_pred_target = 64'h4;
      @(posedge clk); #1;
      chk("x64_beq_taken", 64'(d_out_taken), 64'd1);
      chk("x64_beq_target", d_out_target, 64'h4);
      chk("x64_beq_link", d_out_link, 64'h0);
      chk("x64_beq_mispredict", 64'(d_out_mispredict), 64'd0);
      d_in_valid = 1'b0;

      // BLT signed: -1 < 1.
      s_op = 2'd0; s_f3 = 3'b100; s_pc = 32'h100; s_imm = 32'h20;
      s_rs1 = 32'hFFFF_FFFF; s_rs2 = 32'd1; s_pt = 1'b0; s_ptg = 32'h0;
      cyc(1'b1, 1'b1, 1'b0, acc);
      chk("blt_taken", 64'(out_taken), 64'd1);
      chk("blt_target", 64'(out_target), 64'h120);
      chk("blt_mispredict", 64'(out_mispredict), 64'd1);
      chk("blt_link", 64'(out_link), 64'h104);

      s_f3 = 3'b110;
      cyc(1'b1, 1'b1, 1'b0, acc);
      chk("bltu_taken", 64'(out_taken), 64'd0);
      chk("bltu_target", 64'(out_target), 64'h104);
      chk("bltu_mispredict", 64'(out_mispredict), 64'd0);

      s_op = 2'd2; s_rs1 = 32'h2001; s_imm = 32'd2; s_pt = 1'b1; s_ptg = 32'h2002;
      cyc(1'b1, 1'b1, 1'b0, acc);
      chk("jalr_target", 64'(out_target), 64'h2002);
      chk("jalr_mispredict", 64'(out_mispredict), 64'd0);

      s_imm = 32'd1;
      cyc(1'b1, 1'b1, 1'b0, acc);
      chk("jalr1_target", 64'(out_target), 64'h2002);
      chk("jalr1_misaligned", 64'(out_misaligned), 64'd1);

      s_op = 2'd0; s_f3 = 3'b010; s_pt = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, acc);
      chk("ill_illegal", 64'(out_illegal), 64'd1);
      chk("ill_taken", 64'(out_taken), 64'd0);
      chk("ill_mispredict", 64'(out_mispredict), 64'd0);

      s_op = 2'd3; s_f3 = 3'b000;
      cyc(1'b1, 1'b1, 1'b0, acc);
      chk("rsv_illegal", 64'(out_illegal), 64'd1);

      // Flush with an op presented: op dropped.
      s_op = 2'd1; s_pc = 32'h300; s_imm = 32'h40;
      cyc(1'b1, 1'b1, 1'b1, acc);
      chk("flush_valid", 64'(out_valid), 64'd0);
      cyc(1'b0, 1'b1, 1'b0, acc);
      chk("flush_dropped", 64'(out_valid), 64'd0);
      cyc(1'b0, 1'b1, 1'b1, acc);
      chk("flush_idle", 64'(out_valid), 64'd0);

      // Four back-to-back JALs, consumer stalls for three cycles.
      idx = 0;
      for (int c = 0; c < 12; c++) begin
         s_op = 2'd1; s_pc = 32'h1000 + 32'(idx) * 32'h10; s_imm = 32'h40; s_pt = 1'b1;
         s_ptg = s_pc + 32'h40;
         cyc(idx < 4, !(c >= 1 && c <= 3), 1'b0, acc);
         if (c == 2) chk("bp_held_target", 64'(out_target), 64'h1040);
         if (acc) idx++;
      end
      chk("bp_all_accepted", 64'(idx), 64'd4);

      // Reset while a result is held.
      s_op = 2'd1; s_pc = 32'h500;
      cyc(1'b1, 1'b0, 1'b0, acc);
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      q.delete();
      rst = 1'b0;
      chk("midrst_valid", 64'(out_valid), 64'd0);

      for (int i = 0; i < 400; i++) begin
         s_op  = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
         s_f3  = 3'($urandom_range(0, 7));
         s_rs1 = $urandom;
         case ($urandom_range(0, 3))
            0:       s_rs2 = s_rs1;
            1:       s_rs2 = s_rs1 ^ 32'h8000_0000;
            default: s_rs2 = $urandom;
         endcase
         s_pc  = $urandom & 32'hFFFF_FFFE;
         r12   = 12'($urandom);
         s_imm = {{20{r12[11]}}, r12};
         s_pt  = 1'($urandom);
         if ($urandom_range(0, 1) == 0)
            s_ptg = (s_op == 2'd2) ? ((s_rs1 + s_imm) & 32'hFFFF_FFFE) : (s_pc + s_imm);
         else
            s_ptg = $urandom;
         cyc(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7),
             1'($urandom_range(0, 15) == 0), acc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
